dtm_dmi: RTL and testbench
==========================

# dtm_dmi

JTAG Debug Module Interface (DMI) access register for the RISC-V Debug Transport Module, selected when the TAP IR holds the `dmi` instruction. Shifts `{addr, data, op}` in from TDI, launches read/write requests towards the Debug Module on Update-DR, and captures results and sticky status back into the chain. Supplies the current sticky `op` status to `dtmcs` and consumes its `dmireset`/`dtmhardreset` pulses.

## Interface

**Parameters**
- `ABITS`, default 7: DMI address width. Shift chain width is `ABITS+34`.

**Ports**
- `i_tck` in 1: TCK, sole clock.
- `i_trst_n` in 1: asynchronous active-low reset.
- `i_capture`, `i_shift`, `i_update` in 1 each: TAP DR-state strobes, qualified by IR = dmi.
- `i_tdi` in 1: serial in.
- `o_tdo` out 1: serial out, updated on negedge TCK.
- `i_dtm_reset` in 1: dtmhardreset pulse from `dtmcs`.
- `i_dtm_clear_sticky` in 1: dmireset pulse from `dtmcs`.
- `o_dmi_op` out 2: sticky status to `dtmcs`.
- `o_req_valid` out 1, `i_req_ready` in 1: request handshake.
- `o_req_addr` out ABITS, `o_req_data` out 32, `o_req_op` out 2: request payload (1 = read, 2 = write).
- `i_rsp_valid` in 1: single-cycle response strobe.
- `i_rsp_data` in 32, `i_rsp_op` in 2: response payload (0 = ok, 2 = failed).

## Operation

**Chain layout**
- `[1:0]` op, `[33:2]` data, `[ABITS+33:34]` addr.

**Registers**
- `shift`, `addr_q`, `data_q` (last response data), `sticky` (2 bits), `state`.

**States**
- IDLE: no request outstanding.
- REQ: `o_req_valid` = 1, payload held stable.
- WAIT: awaiting `i_rsp_valid`.

**Capture**
- Loads `{addr_q, data_q, st}`.
- `st` = 3 if state != IDLE; in that case `sticky` is also set to 3.
- Otherwise `st` = `sticky`.

**Shift**
- LSB-first right shift; `i_tdi` enters at the MSB.

**Update**
- Acts only if state = IDLE and `sticky` = 0, and chain op is 1 or 2.
- Latches addr, data and op into the request registers and goes IDLE→REQ.
- Op 0 or 3: no action.
- Update while not IDLE: ignored, and `sticky` is set to 3.
- Update while `sticky` != 0: ignored, `sticky` unchanged.

**Transitions**
- REQ→WAIT when `o_req_valid & i_req_ready`.
- WAIT→IDLE on `i_rsp_valid`:
  - `data_q` ← `i_rsp_data`.
  - If `i_rsp_op` != 0 and `sticky` = 0, `sticky` ← `i_rsp_op`.
- `i_rsp_valid` in IDLE or REQ is ignored.

**Priority within one cycle**
- `i_dtm_reset` > `i_dtm_clear_sticky` > capture/shift/update/response.
- `i_dtm_reset`: state → IDLE, `sticky` ← 0, outstanding request abandoned. A later response is dropped because state is IDLE.
- `i_dtm_clear_sticky`: `sticky` ← 0 only; state and outstanding request are not touched.

**Status output**
- `o_dmi_op` = `sticky` (registered).

## Timing

- Reset values:
  - All outputs 0 (`o_tdo`, `o_dmi_op`, `o_req_valid`, `o_req_addr`, `o_req_data`, `o_req_op`).
  - state IDLE; `shift`, `addr_q`, `data_q`, `sticky` all 0.
- `i_trst_n` assertion mid-transaction drops `o_req_valid` immediately (asynchronous).
- Update at posedge N → `o_req_valid` high from N+1.
- Handshake at posedge M → `o_req_valid` low from M+1.
- Response at posedge K → state IDLE and `data_q` valid from K+1; a capture at K+1 reads the new data.
- Fastest turnaround: `i_req_ready` tied high, response in the cycle after the handshake, giving 3 TCK from Update to IDLE.
- `o_tdo` follows `shift[0]` at each negedge TCK.

## Structure

- Shared package `dtm_pkg`:
  - Op encodings: `DMI_OP_NOP`=0, `DMI_OP_READ`=1, `DMI_OP_WRITE`=2.
  - Status encodings: `DMI_ST_OK`=0, `DMI_ST_FAILED`=2, `DMI_ST_BUSY`=3.
  - State enum `dmi_state_t` {IDLE, REQ, WAIT}.
  - `dtmcs` imports the same status encodings.
- Single flat module; no sub-module is warranted.

## Test plan

1. **Reset:** assert `i_trst_n`=0 mid-REQ → all outputs 0 asynchronously; capture afterwards shifts out all zeros.
2. **Write:** shift addr 0x10, data 0xDEADBEEF, op 2; pulse update.
   - Next cycle: `o_req_valid`=1, `o_req_addr`=0x10, `o_req_data`=0xDEADBEEF, `o_req_op`=2, held stable through 3 cycles of `i_req_ready`=0.
   - Response with op 0 → capture yields op 0.
3. **Read:** op 1 at addr 0x11; response data 0x12345678, op 0 → next capture shifts out data field 0x12345678, addr 0x11, op 0.
4. **Busy:** capture while in WAIT → op field 3 and `o_dmi_op`=3.
   - A subsequent update with op 1 produces no `o_req_valid`.
   - `i_dtm_clear_sticky` pulse → `o_dmi_op`=0 next cycle.
5. **Failed:** response with `i_rsp_op`=2 → `o_dmi_op`=2.
   - A later write update is ignored until `i_dtm_clear_sticky`; after the clear, the write issues normally.
6. **Hard reset:** `i_dtm_reset` during REQ → `o_req_valid`=0 next cycle.
   - A late `i_rsp_valid` with data 0xFFFFFFFF leaves `data_q` unchanged and `o_dmi_op`=0.

Source files
------------

// File: rtl/dtm_pkg.sv
// Shared DTM definitions: DMI op/status encodings, the DMI access FSM states,
// and a small op decode helper used by dtm_dmi (and dtmcs for the status codes).
package dtm_pkg;

    localparam logic [1:0] DMI_OP_NOP    = 2'd0;
    localparam logic [1:0] DMI_OP_READ   = 2'd1;
    localparam logic [1:0] DMI_OP_WRITE  = 2'd2;

    localparam logic [1:0] DMI_ST_OK     = 2'd0;
    localparam logic [1:0] DMI_ST_FAILED = 2'd2;
    localparam logic [1:0] DMI_ST_BUSY   = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } dmi_state_t;

    function automatic logic is_access_op(input logic [1:0] op);
        return (op == DMI_OP_READ) || (op == DMI_OP_WRITE);
    endfunction

endpackage

// File: rtl/dtm_dmi.sv
// JTAG DMI access register: shifts {addr, data, op}, launches Debug Module
// requests on Update-DR and reports sticky busy/failed status back to the host.
module dtm_dmi
    import dtm_pkg::*;
#(
    parameter int ABITS = 7
) (
    input  logic             i_tck,
    input  logic             i_trst_n,
    input  logic             i_capture,
    input  logic             i_shift,
    input  logic             i_update,
    input  logic             i_tdi,
    output logic             o_tdo,
    input  logic             i_dtm_reset,
    input  logic             i_dtm_clear_sticky,
    output logic [1:0]       o_dmi_op,
    output logic             o_req_valid,
    input  logic             i_req_ready,
    output logic [ABITS-1:0] o_req_addr,
    output logic [31:0]      o_req_data,
    output logic [1:0]       o_req_op,
    input  logic             i_rsp_valid,
    input  logic [31:0]      i_rsp_data,
    input  logic [1:0]       i_rsp_op
);

    localparam int SW = ABITS + 34;

    logic [SW-1:0]    shift_q, shift_d;
    logic [ABITS-1:0] addr_q, addr_d;
    logic [31:0]      data_q, data_d;
    logic [31:0]      req_data_q, req_data_d;
    logic [1:0]       req_op_q, req_op_d;
    logic [1:0]       sticky_q, sticky_d;
    dmi_state_t       state_q, state_d;
    logic             tdo_q;

    logic [1:0]       chain_op;
    logic [31:0]      chain_data;
    logic [ABITS-1:0] chain_addr;
    logic             busy;

    assign chain_op   = shift_q[1:0];
    assign chain_data = shift_q[33:2];
    assign chain_addr = shift_q[SW-1:34];
    assign busy       = (state_q != IDLE);

    always_comb begin
        shift_d    = shift_q;
        addr_d     = addr_q;
        data_d     = data_q;
        req_data_d = req_data_q;
        req_op_d   = req_op_q;
        sticky_d   = sticky_q;
        state_d    = state_q;

        if (i_dtm_reset) begin
            // Abandon any outstanding request; a late response then finds IDLE and is dropped.
            state_d  = IDLE;
            sticky_d = DMI_ST_OK;
        end else begin
            case (state_q)
                REQ: begin
                    if (i_req_ready) begin
                        state_d = WAIT;
                    end
                end
                WAIT: begin
                    if (i_rsp_valid) begin
                        state_d = IDLE;
                        data_d  = i_rsp_data;
                        if ((i_rsp_op != DMI_ST_OK) && (sticky_q == DMI_ST_OK)) begin
                            sticky_d = i_rsp_op;
                        end
                    end
                end
                default: ;
            endcase

            // Host activity while a request is in flight is a busy error, and it sticks.
            if (i_capture) begin
                shift_d = {addr_q, data_q, (busy ? DMI_ST_BUSY : sticky_q)};
                if (busy) begin
                    sticky_d = DMI_ST_BUSY;
                end
            end else if (i_shift) begin
                shift_d = {i_tdi, shift_q[SW-1:1]};
            end else if (i_update) begin
                if (busy) begin
                    sticky_d = DMI_ST_BUSY;
                end else if ((sticky_q == DMI_ST_OK) && is_access_op(chain_op)) begin
                    addr_d     = chain_addr;
                    req_data_d = chain_data;
                    req_op_d   = chain_op;
                    state_d    = REQ;
                end
            end

            if (i_dtm_clear_sticky) begin
                sticky_d = DMI_ST_OK;
            end
        end
    end

    always_ff @(posedge i_tck or negedge i_trst_n) begin
        if (!i_trst_n) begin
            shift_q    <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            req_data_q <= '0;
            req_op_q   <= DMI_OP_NOP;
            sticky_q   <= DMI_ST_OK;
            state_q    <= IDLE;
        end else begin
            shift_q    <= shift_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            req_data_q <= req_data_d;
            req_op_q   <= req_op_d;
            sticky_q   <= sticky_d;
            state_q    <= state_d;
        end
    end

    // TDO changes on the falling edge so the host samples a settled bit on the rising edge.
    always_ff @(negedge i_tck or negedge i_trst_n) begin
        if (!i_trst_n) begin
            tdo_q <= 1'b0;
        end else begin
            tdo_q <= shift_q[0];
        end
    end

    assign o_tdo       = tdo_q;
    assign o_dmi_op    = sticky_q;
    assign o_req_valid = (state_q == REQ);
    assign o_req_addr  = addr_q;
    assign o_req_data  = req_data_q;
    assign o_req_op    = req_op_q;

endmodule

// File: tb/tb_dtm_dmi.sv
// Bench for dtm_dmi: directed scenarios followed by random host/DM activity,
// all checked against a transaction-level model of the DMI register.
module tb_dtm_dmi;

    localparam int ABITS = 7;
    localparam int W     = ABITS + 34;

    logic             i_tck = 1'b0;
    logic             i_trst_n = 1'b0;
    logic             i_capture = 1'b0;
    logic             i_shift = 1'b0;
    logic             i_update = 1'b0;
    logic             i_tdi = 1'b0;
    logic             o_tdo;
    logic             i_dtm_reset = 1'b0;
    logic             i_dtm_clear_sticky = 1'b0;
    logic [1:0]       o_dmi_op;
    logic             o_req_valid;
    logic             i_req_ready = 1'b0;
    logic [ABITS-1:0] o_req_addr;
    logic [31:0]      o_req_data;
    logic [1:0]       o_req_op;
    logic             i_rsp_valid = 1'b0;
    logic [31:0]      i_rsp_data = '0;
    logic [1:0]       i_rsp_op = '0;

    int checks = 0;
    int errors = 0;

    // Model: a launched request is "pending" until answered; "accepted" once handshaken.
    logic [ABITS-1:0] m_addr;
    logic [31:0]      m_data;
    logic [31:0]      m_req_data;
    logic [1:0]       m_req_op;
    logic [1:0]       m_sticky;
    bit               m_pend;
    bit               m_acc;

    always #5 i_tck = ~i_tck;

    dtm_dmi #(.ABITS(ABITS)) dut (
        .i_tck              (i_tck),
        .i_trst_n           (i_trst_n),
        .i_capture          (i_capture),
        .i_shift            (i_shift),
        .i_update           (i_update),
        .i_tdi              (i_tdi),
        .o_tdo              (o_tdo),
        .i_dtm_reset        (i_dtm_reset),
        .i_dtm_clear_sticky (i_dtm_clear_sticky),
        .o_dmi_op           (o_dmi_op),
        .o_req_valid        (o_req_valid),
        .i_req_ready        (i_req_ready),
        .o_req_addr         (o_req_addr),
        .o_req_data         (o_req_data),
        .o_req_op           (o_req_op),
        .i_rsp_valid        (i_rsp_valid),
        .i_rsp_data         (i_rsp_data),
        .i_rsp_op           (i_rsp_op)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge i_tck);
        #1;
    endtask

    task automatic model_reset();
        m_addr = '0; m_data = '0; m_req_data = '0; m_req_op = '0;
        m_sticky = '0; m_pend = 0; m_acc = 0;
    endtask

    task automatic check_outputs(input string tag);
        chk($sformatf("%s.valid", tag), o_req_valid, (m_pend && !m_acc));
        chk($sformatf("%s.dmi_op", tag), o_dmi_op, m_sticky);
        if (m_pend && !m_acc) begin
            chk($sformatf("%s.addr", tag), o_req_addr, m_addr);
            chk($sformatf("%s.data", tag), o_req_data, m_req_data);
            chk($sformatf("%s.op", tag), o_req_op, m_req_op);
        end
    endtask

    // Full Capture/Shift/Update pass; returns nothing but checks the shifted-out word.
    task automatic scan(input logic [ABITS-1:0] a, input logic [31:0] d,
                        input logic [1:0] op, input string tag);
        logic [W-1:0] din, dout, exp;
        din = {a, d, op};
        exp = {m_addr, m_data, (m_pend ? 2'd3 : m_sticky)};
        if (m_pend) m_sticky = 2'd3;
        i_capture = 1'b1;
        step();
        i_capture = 1'b0;
        for (int i = 0; i < W; i++) begin
            @(negedge i_tck);
            #1;
            dout[i] = o_tdo;
            i_shift = 1'b1;
            i_tdi   = din[i];
            step();
        end
        i_shift = 1'b0;
        i_tdi   = 1'b0;
        chk($sformatf("%s.capture", tag), dout, exp);
        i_update = 1'b1;
        step();
        i_update = 1'b0;
        if (m_pend) begin
            m_sticky = 2'd3;
        end else if (m_sticky == 2'd0 && (op == 2'd1 || op == 2'd2)) begin
            m_addr = a; m_req_data = d; m_req_op = op;
            m_pend = 1; m_acc = 0;
        end
        check_outputs(tag);
    endtask

    task automatic handshake(input int waits, input string tag);
        for (int i = 0; i < waits; i++) begin
            step();
            check_outputs($sformatf("%s.hold%0d", tag, i));
        end
        i_req_ready = 1'b1;
        step();
        i_req_ready = 1'b0;
        if (m_pend && !m_acc) m_acc = 1;
        check_outputs(tag);
    endtask

    task automatic respond(input logic [31:0] d, input logic [1:0] op, input string tag);
        i_rsp_valid = 1'b1;
        i_rsp_data  = d;
        i_rsp_op    = op;
        step();
        i_rsp_valid = 1'b0;
        if (m_pend && m_acc) begin
            m_data = d;
            if (op != 2'd0 && m_sticky == 2'd0) m_sticky = op;
            m_pend = 0; m_acc = 0;
        end
        check_outputs(tag);
    endtask

    task automatic clear_sticky(input string tag);
        i_dtm_clear_sticky = 1'b1;
        step();
        i_dtm_clear_sticky = 1'b0;
        m_sticky = 2'd0;
        check_outputs(tag);
    endtask

    task automatic hard_reset(input string tag);
        i_dtm_reset = 1'b1;
        step();
        i_dtm_reset = 1'b0;
        m_sticky = 2'd0; m_pend = 0; m_acc = 0;
        check_outputs(tag);
    endtask

    task automatic check_all_zero(input string tag);
        chk($sformatf("%s.tdo", tag), o_tdo, 1'b0);
        chk($sformatf("%s.valid", tag), o_req_valid, 1'b0);
        chk($sformatf("%s.dmi_op", tag), o_dmi_op, 2'd0);
        chk($sformatf("%s.addr", tag), o_req_addr, '0);
        chk($sformatf("%s.data", tag), o_req_data, 32'd0);
        chk($sformatf("%s.op", tag), o_req_op, 2'd0);
    endtask

    initial begin
        int sel;
        model_reset();
        #12;
        check_all_zero("por");
        i_trst_n = 1'b1;
        step();

        scan(7'h10, 32'hDEADBEEF, 2'd2, "write");
        handshake(3, "write_hs");
        respond(32'h0, 2'd0, "write_rsp");
        scan(7'h00, 32'h0, 2'd0, "write_status");

        scan(7'h11, 32'h0, 2'd1, "read");
        handshake(0, "read_hs");
        respond(32'h12345678, 2'd0, "read_rsp");
        scan(7'h00, 32'h0, 2'd0, "read_result");

        scan(7'h22, 32'h0, 2'd1, "busy_launch");
        handshake(0, "busy_hs");
        scan(7'h23, 32'h0, 2'd1, "busy_capture");
        respond(32'hCAFE0001, 2'd0, "busy_rsp");
        clear_sticky("busy_clear");

        scan(7'h30, 32'h55AA55AA, 2'd2, "fail_launch");
        handshake(1, "fail_hs");
        respond(32'h0BADF00D, 2'd2, "fail_rsp");
        scan(7'h31, 32'h11111111, 2'd2, "fail_blocked");
        clear_sticky("fail_clear");
        scan(7'h32, 32'h22222222, 2'd2, "fail_retry");
        handshake(0, "fail_retry_hs");
        respond(32'h0, 2'd0, "fail_retry_rsp");

        scan(7'h40, 32'h33333333, 2'd2, "hr_launch");
        hard_reset("hr");
        handshake(0, "hr_stray_ready");
        respond(32'hFFFFFFFF, 2'd2, "hr_late_rsp");
        scan(7'h00, 32'h0, 2'd0, "hr_status");

        scan(7'h55, 32'h44444444, 2'd1, "trst_launch");
        #2;
        i_trst_n = 1'b0;
        #1;
        model_reset();
        check_all_zero("trst_async");
        #10;
        i_trst_n = 1'b1;
        step();
        scan(7'h00, 32'h0, 2'd0, "trst_zero_capture");

        for (int n = 0; n < 60; n++) begin
            sel = $urandom_range(0, 9);
            if (sel <= 3) begin
                scan(7'($urandom), 32'($urandom), 2'($urandom_range(0, 3)), $sformatf("rnd%0d.scan", n));
            end else if (sel <= 5) begin
                handshake($urandom_range(0, 3), $sformatf("rnd%0d.hs", n));
            end else if (sel <= 7) begin
                respond(32'($urandom), 2'($urandom_range(0, 3)), $sformatf("rnd%0d.rsp", n));
            end else if (sel == 8) begin
                clear_sticky($sformatf("rnd%0d.clr", n));
            end else begin
                hard_reset($sformatf("rnd%0d.hr", n));
            end
        end
        scan(7'h00, 32'h0, 2'd0, "final_status");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
